// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : imm_gen_pipe
// Purpose  : Registered immediate generator for the decode stage. Accepts one
//            32-bit instruction per cycle on a valid/ready handshake and one
//            cycle later presents the XLEN-wide immediate, a format code, an
//            illegal flag and a passthrough tag.
// Ports    : clk, rst_n (async active-low), flush (kills output stage)
//            in_valid/in_ready/in_inst/in_tag   - upstream handshake
//            out_valid/out_ready                - downstream handshake
//            out_imm/out_fmt/out_illegal/out_tag - registered result
//            out_fmt: 0=none/R 1=I 2=S 3=B 4=U 5=J 6=CSR-zimm 7=illegal
// Revision : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [2:0] c_fmt_r    = 3'd0;
    localparam logic [2:0] c_fmt_i    = 3'd1;
    localparam logic [2:0] c_fmt_s    = 3'd2;
    localparam logic [2:0] c_fmt_b    = 3'd3;
    localparam logic [2:0] c_fmt_u    = 3'd4;
    localparam logic [2:0] c_fmt_j    = 3'd5;
    localparam logic [2:0] c_fmt_csr  = 3'd6;
    localparam logic [2:0] c_fmt_ill  = 3'd7;

    localparam logic [4:0] c_opc_load     = 5'b00000;
    localparam logic [4:0] c_opc_misc_mem = 5'b00011;
    localparam logic [4:0] c_opc_op_imm   = 5'b00100;
    localparam logic [4:0] c_opc_auipc    = 5'b00101;
    localparam logic [4:0] c_opc_op_imm_w = 5'b00110;
    localparam logic [4:0] c_opc_store    = 5'b01000;
    localparam logic [4:0] c_opc_op       = 5'b01100;
    localparam logic [4:0] c_opc_lui      = 5'b01101;
    localparam logic [4:0] c_opc_op_w     = 5'b01110;
    localparam logic [4:0] c_opc_branch   = 5'b11000;
    localparam logic [4:0] c_opc_jalr     = 5'b11001;
    localparam logic [4:0] c_opc_jal      = 5'b11011;
    localparam logic [4:0] c_opc_system   = 5'b11100;

    // The *-W opcodes only exist on RV64.
    localparam bit c_rv64 = (XLEN == 64);

    logic             r_valid;
    logic [XLEN-1:0]  r_imm;
    logic [2:0]       r_fmt;
    logic [TAG_W-1:0] r_tag;

    logic             w_load;
    logic [4:0]       w_opc;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic [XLEN-1:0]  w_imm_i;
    logic [XLEN-1:0]  w_imm_s;
    logic [XLEN-1:0]  w_imm_b;
    logic [XLEN-1:0]  w_imm_u;
    logic [XLEN-1:0]  w_imm_j;
    logic [XLEN-1:0]  w_imm_csr;
    logic [XLEN-1:0]  w_imm_zimm;
    logic             w_unused;

    // funct3[1:0] never influences the immediate.
    assign w_unused = ^in_inst[13:12];

    assign w_opc = in_inst[6:2];

    // Signed casts to XLEN replicate the field MSB into all upper bits.
    assign w_imm_i    = XLEN'($signed(in_inst[31:20]));
    assign w_imm_s    = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
    assign w_imm_b    = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                       in_inst[11:8], 1'b0}));
    assign w_imm_u    = XLEN'($signed({in_inst[31:12], 12'b0}));
    assign w_imm_j    = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                       in_inst[30:21], 1'b0}));
    // CSR address and zimm are unsigned fields.
    assign w_imm_csr  = XLEN'(in_inst[31:20]);
    assign w_imm_zimm = XLEN'(in_inst[19:15]);

    always_comb begin
        w_imm = '0;
        w_fmt = c_fmt_ill;
        if (in_inst[1:0] == 2'b11) begin
            case (w_opc)
                c_opc_op: begin
                    w_fmt = c_fmt_r;
                end
                c_opc_op_w: begin
                    if (c_rv64) w_fmt = c_fmt_r;
                end
                c_opc_op_imm, c_opc_load, c_opc_jalr, c_opc_misc_mem: begin
                    w_imm = w_imm_i;
                    w_fmt = c_fmt_i;
                end
                c_opc_op_imm_w: begin
                    if (c_rv64) begin
                        w_imm = w_imm_i;
                        w_fmt = c_fmt_i;
                    end
                end
                c_opc_store: begin
                    w_imm = w_imm_s;
                    w_fmt = c_fmt_s;
                end
                c_opc_branch: begin
                    w_imm = w_imm_b;
                    w_fmt = c_fmt_b;
                end
                c_opc_lui, c_opc_auipc: begin
                    w_imm = w_imm_u;
                    w_fmt = c_fmt_u;
                end
                c_opc_jal: begin
                    w_imm = w_imm_j;
                    w_fmt = c_fmt_j;
                end
                c_opc_system: begin
                    if (in_inst[14]) begin
                        w_imm = w_imm_zimm;
                        w_fmt = c_fmt_csr;
                    end else begin
                        w_imm = w_imm_csr;
                        w_fmt = c_fmt_i;
                    end
                end
                default: begin
                    w_imm = '0;
                    w_fmt = c_fmt_ill;
                end
            endcase
        end
    end

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_imm   <= '0;
            r_fmt   <= c_fmt_r;
            r_tag   <= '0;
        end else begin
            if (flush) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end else if (r_valid && out_ready) begin
                r_valid <= 1'b0;
            end
            // Data only moves on a real load; holds during stalls.
            if (w_load) begin
                r_imm <= w_imm;
                r_fmt <= w_fmt;
                r_tag <= in_tag;
            end
        end
    end

    assign out_valid   = r_valid;
    assign out_imm     = r_imm;
    assign out_fmt     = r_fmt;
    assign out_illegal = (r_fmt == c_fmt_ill);
    assign out_tag     = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_imm_gen_pipe
// Purpose  : Self-checking bench for imm_gen_pipe. Drives an XLEN=32 and an
//            XLEN=64 instance; expected results are queued on acceptance and
//            compared when each instance hands a result downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imm_gen_pipe;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] tag;
    } exp_t;

    typedef struct {
        bit          x64;
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        f32, v32, rdy32, ir32, ov32, ill32;
    logic [31:0] inst32, tag32, imm32, otag32;
    logic [2:0]  fmt32;
    logic        f64, v64, rdy64, ir64, ov64, ill64;
    logic [31:0] inst64, tag64, otag64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;

    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   tag_ctr  = 0;
    exp_t cur32, cur64;
    exp_t q32[$];
    exp_t q64[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .flush(f32),
        .in_valid(v32), .in_ready(ir32), .in_inst(inst32), .in_tag(tag32),
        .out_valid(ov32), .out_ready(rdy32), .out_imm(imm32), .out_fmt(fmt32),
        .out_illegal(ill32), .out_tag(otag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .flush(f64),
        .in_valid(v64), .in_ready(ir64), .in_inst(inst64), .in_tag(tag64),
        .out_valid(ov64), .out_ready(rdy64), .out_imm(imm64), .out_fmt(fmt64),
        .out_illegal(ill64), .out_tag(otag64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit x64, input logic [31:0] inst,
                         input logic [63:0] imm, input logic [2:0] fmt);
        tag_ctr++;
        if (x64) begin
            v64 = 1'b1; inst64 = inst; tag64 = tag_ctr;
            cur64 = '{imm: imm, fmt: fmt, tag: tag_ctr};
        end else begin
            v32 = 1'b1; inst32 = inst; tag32 = tag_ctr;
            cur32 = '{imm: imm, fmt: fmt, tag: tag_ctr};
        end
    endtask

    // Scoreboards: compare on output handshake, enqueue on input handshake.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ov32 && rdy32) begin
                if (q32.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb32: unexpected output tag %h, expected none", otag32);
                end else begin
                    e = q32.pop_front();
                    chk("imm32", 64'(imm32), 64'(e.imm[31:0]));
                    chk("fmt32", 64'(fmt32), 64'(e.fmt));
                    chk("ill32", 64'(ill32), 64'(e.fmt == 3'd7));
                    chk("tag32", 64'(otag32), 64'(e.tag));
                end
            end else if (f32 && ov32 && q32.size() > 0) begin
                void'(q32.pop_front());
            end
            if (v32 && ir32 && !f32) q32.push_back(cur32);

            if (ov64 && rdy64) begin
                if (q64.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL sb64: unexpected output tag %h, expected none", otag64);
                end else begin
                    e = q64.pop_front();
                    chk("imm64", imm64, e.imm);
                    chk("fmt64", 64'(fmt64), 64'(e.fmt));
                    chk("ill64", 64'(ill64), 64'(e.fmt == 3'd7));
                    chk("tag64", 64'(otag64), 64'(e.tag));
                end
            end else if (f64 && ov64 && q64.size() > 0) begin
                void'(q64.pop_front());
            end
            if (v64 && ir64 && !f64) q64.push_back(cur64);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        f32 = 0; v32 = 0; rdy32 = 1; inst32 = 0; tag32 = 0;
        f64 = 0; v64 = 0; rdy64 = 1; inst64 = 0; tag64 = 0;

        vecs.push_back('{0, 32'hFFF00093, 64'hFFFFFFFF, 3'd1});
        vecs.push_back('{0, 32'h00000463, 64'h00000008, 3'd3});
        vecs.push_back('{0, 32'h3412D073, 64'h00000005, 3'd6});
        vecs.push_back('{0, 32'h00000000, 64'h0,        3'd7});
        vecs.push_back('{0, 32'h12345672, 64'h0,        3'd7});
        vecs.push_back('{0, 32'h0000001B, 64'h0,        3'd7});
        vecs.push_back('{0, 32'h0000003B, 64'h0,        3'd7});
        vecs.push_back('{0, 32'h800000B7, 64'h80000000, 3'd4});
        vecs.push_back('{0, 32'hFE112E23, 64'hFFFFFFFC, 3'd2});
        vecs.push_back('{0, 32'hFFDFF06F, 64'hFFFFFFFC, 3'd5});
        vecs.push_back('{0, 32'hC00020F3, 64'h00000C00, 3'd1});
        vecs.push_back('{0, 32'h12345097, 64'h12345000, 3'd4});
        vecs.push_back('{0, 32'h002081B3, 64'h0,        3'd0});
        vecs.push_back('{0, 32'hFE0008E3, 64'hFFFFFFF0, 3'd3});
        vecs.push_back('{0, 32'h7FF02083, 64'h000007FF, 3'd1});
        vecs.push_back('{0, 32'h0FF0000F, 64'h000000FF, 3'd1});
        vecs.push_back('{1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4});
        vecs.push_back('{1, 32'h0000001B, 64'h0,                3'd1});
        vecs.push_back('{1, 32'h0000003B, 64'h0,                3'd0});
        vecs.push_back('{1, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1});
        vecs.push_back('{1, 32'hC00020F3, 64'h0000000000000C00, 3'd1});
        vecs.push_back('{1, 32'h3412D073, 64'h0000000000000005, 3'd6});
        vecs.push_back('{1, 32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5});
        vecs.push_back('{1, 32'h00000000, 64'h0,                3'd7});

        // Reset state
        #12;
        chk("rst_valid32", 64'(ov32), 64'd0);
        chk("rst_imm32",   64'(imm32), 64'd0);
        chk("rst_fmt32",   64'(fmt32), 64'd0);
        chk("rst_ill32",   64'(ill32), 64'd0);
        chk("rst_tag32",   64'(otag32), 64'd0);
        chk("rst_ready32", 64'(ir32), 64'd1);
        chk("rst_valid64", 64'(ov64), 64'd0);
        chk("rst_imm64",   imm64, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table: back-to-back on each instance
        foreach (vecs[i]) begin
            v32 = 0; v64 = 0;
            drive(vecs[i].x64, vecs[i].inst, vecs[i].imm, vecs[i].fmt);
            step();
        end
        v32 = 0; v64 = 0;
        repeat (3) step();
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);

        // Back-pressure: jal held for 3 cycles, second input waits
        rdy32 = 0;
        drive(0, 32'h0080006F, 64'h8, 3'd5);
        step();
        drive(0, 32'h00500093, 64'h5, 3'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 64'(ov32), 64'd1);
            chk("bp_imm",   64'(imm32), 64'h8);
            chk("bp_fmt",   64'(fmt32), 64'd5);
            chk("bp_ready", 64'(ir32), 64'd0);
        end
        step();
        rdy32 = 1;
        @(negedge clk);
        chk("bp_release_ready", 64'(ir32), 64'd1);
        step();
        v32 = 0;
        repeat (2) step();
        chk("bp_drain", 64'(q32.size()), 64'd0);

        // Flush with a held result and a new input present
        rdy32 = 0;
        drive(0, 32'h00100093, 64'h1, 3'd1);
        step();
        drive(0, 32'h00200113, 64'h2, 3'd1);
        rdy32 = 1;
        f32 = 1;
        step();
        f32 = 0;
        v32 = 0;
        @(negedge clk);
        chk("flush_valid", 64'(ov32), 64'd0);
        step();
        drive(0, 32'h00300193, 64'h3, 3'd1);
        step();
        v32 = 0;
        repeat (2) step();
        chk("flush_drain", 64'(q32.size()), 64'd0);

        // Asynchronous reset during a stall
        rdy32 = 0; rdy64 = 0;
        drive(0, 32'hFFF00093, 64'hFFFFFFFF, 3'd1);
        drive(1, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
        step();
        v32 = 0; v64 = 0;
        @(negedge clk);
        chk("stall_valid32", 64'(ov32), 64'd1);
        chk("stall_valid64", 64'(ov64), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid32", 64'(ov32), 64'd0);
        chk("arst_imm32",   64'(imm32), 64'd0);
        chk("arst_fmt32",   64'(fmt32), 64'd0);
        chk("arst_tag32",   64'(otag32), 64'd0);
        chk("arst_valid64", 64'(ov64), 64'd0);
        chk("arst_imm64",   imm64, 64'd0);
        chk("arst_fmt64",   64'(fmt64), 64'd0);
        chk("arst_ill64",   64'(ill64), 64'd0);
        chk("arst_tag64",   64'(otag64), 64'd0);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready32", 64'(ir32), 64'd1);
        chk("post_rst_ready64", 64'(ir64), 64'd1);

        // Normal operation after reset
        rdy64 = 1;
        step();
        drive(1, 32'h0000001B, 64'h0, 3'd1);
        step();
        v64 = 0;
        repeat (2) step();
        chk("post_rst_drain64", 64'(q64.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, registered immediate generator for the decode stage.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake.
- One cycle later it presents the XLEN-wide immediate, a format code, an illegal flag and a passthrough tag.
- Adds to the combinational extender: RV64 support, SYSTEM/CSR and FENCE immediates, illegal-opcode detection, back-pressure and flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
TAG_W, 32, width of the sideband tag (normally the PC); passed through unchanged.

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of the output stage (branch redirect)
in_valid  input  1  in_inst/in_tag valid
in_ready  output  1  stage can accept this cycle
in_inst  input  32  instruction word
in_tag  input  TAG_W  sideband tag
out_valid  output  1  output registers hold a result
out_ready  input  1  consumer accepts this cycle
out_imm  output  XLEN  extended immediate
out_fmt  output  3  0=none/R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=CSR-zimm, 7=illegal
out_illegal  output  1  instruction not decodable
out_tag  output  TAG_W  tag registered alongside the result

Behaviour:
- Reset: asynchronous assert, synchronous deassert (external sync assumed). While rst_n=0: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0. Reset mid-transfer drops the held entry.
- Handshake:
  - in_ready = !out_valid || out_ready. This is a combinational path from out_ready, which is permitted.
  - Load when in_valid && in_ready && !flush: result registers take the decode of in_inst; out_valid<=1.
  - Consume only, no load (out_valid && out_ready): out_valid<=0.
  - Otherwise registers hold; out_* stay stable while out_valid && !out_ready.
- Latency 1 cycle; throughput 1 instruction/cycle with out_ready held high.
- flush=1: out_valid<=0 next cycle regardless of other inputs. Any input presented that cycle is dropped. Data registers may update or hold; they are don't-care while out_valid=0.
- Decode on opc=inst[6:2]. sx(v) means sign-extend v to XLEN from its MSB; zx means zero-extend.
  - inst[1:0]!=2'b11 -> illegal.
  - 01100 R: imm=0, fmt 0.
  - 01110 R-W: as R if XLEN=64, else illegal.
  - 00100 OP-IMM, 00000 LOAD, 11001 JALR, 00011 MISC-MEM: imm=sx(inst[31:20]), fmt 1.
  - 00110 OP-IMM-W: fmt 1 if XLEN=64, else illegal.
  - 01000 STORE: imm=sx({inst[31:25],inst[11:7]}), fmt 2.
  - 11000 BRANCH: imm=sx({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}), fmt 3.
  - 01101 LUI, 00101 AUIPC: imm=sx({inst[31:12],12'b0}), fmt 4. Bits above 31 replicate inst[31] when XLEN=64.
  - 11011 JAL: imm=sx({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}), fmt 5.
  - 11100 SYSTEM:
    - inst[14]=1: imm=zx(inst[19:15]), fmt 6.
    - inst[14]=0: imm=zx(inst[31:20]) (CSR address / ECALL code), fmt 1.
  - Any other opcode: illegal.
- Illegal result: imm=0, fmt 7, out_illegal=1. It still occupies a slot and is handed downstream; the stage never stalls on it.
- out_illegal=1 if and only if fmt=7.

Test Plan:
1. XLEN=32, out_ready=1, back-to-back inputs:
   - 0xFFF00093 (addi x1,x0,-1) -> next cycle imm=0xFFFFFFFF, fmt 1.
   - Then 0x00000463 (beq +8) -> imm=0x00000008, fmt 3.
   - Both use consecutive cycles with in_ready held 1.
2. XLEN=64:
   - 0x800000B7 (lui x1,0x80000) -> imm=0xFFFFFFFF80000000, fmt 4.
   - 0x0000001B (addiw) -> fmt 1, illegal=0.
   - The same addiw with XLEN=32 -> fmt 7, illegal=1, imm=0.
3. Back-pressure:
   - Load 0x0080006F (jal +8) with out_ready=0 for 3 cycles.
   - Expected: out_valid=1, imm=0x00000008 and fmt 5 stable, in_ready=0.
   - A second input held on in_valid is accepted only in the cycle out_ready rises.
4. CSR and illegal:
   - 0x3412D073 (csrrwi, zimm=5) -> imm=5, fmt 6.
   - 0x00000000 -> fmt 7, illegal=1.
   - 0x12345672 (inst[1:0]=10) -> fmt 7.
5. Flush: with out_valid=1 and a new in_valid, assert flush for 1 cycle -> next cycle out_valid=0, the new input is not delivered, and the following accepted input decodes normally.
6. Reset mid-stall: out_valid=1 and out_ready=0, drop rst_n between clock edges -> out_valid=0 and all outputs 0 immediately, without waiting for a clock edge; after release, in_ready=1.
